// File: rtl/sc_job_ctrl.sv
// sc_job_ctrl: per-job sequencer for a stochastic-computing app instance.
// Latches operands, restarts the app, stops on done or a cycle cap, and reports Bz plus cycles used.
module sc_job_ctrl #(
    parameter  int W        = 4,
    parameter  int N        = 4,
    parameter  int NC       = 1,
    parameter  int CORR     = 0,
    localparam int TW       = (CORR != 0) ? W + NC : W * N + NC,
    parameter  int LEN_W    = TW,
    parameter  int USE_DONE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0][W-1:0]     in_Bxs,
    output logic                    app_rst_n,
    output logic [N-1:0][W-1:0]     app_Bxs,
    input  logic [TW-1:0]           app_Bz,
    input  logic                    app_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TW-1:0]           out_Bz,
    output logic [LEN_W:0]          out_cycles,
    output logic                    out_early
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_t;
    localparam logic [LEN_W:0] CAP = {1'b1, {LEN_W{1'b0}}};

    state_t               state_q, state_d;
    logic [LEN_W:0]       cyc_q, cyc_d, cycles_q, cycles_d;
    logic [N-1:0][W-1:0]  bxs_q, bxs_d;
    logic [TW-1:0]        bz_q, bz_d;
    logic                 early_q, early_d, valid_q, valid_d, app_rst_q;
    logic                 hit_done, stop;

    // A done flag seen at cyc 0 is left over from the previous job and is ignored.
    assign hit_done   = (USE_DONE != 0) && app_done && (cyc_q != '0);
    assign stop       = hit_done || (cyc_q == CAP);
    assign in_ready   = (state_q == IDLE);
    assign app_rst_n  = app_rst_q;
    assign app_Bxs    = bxs_q;
    assign out_valid  = valid_q;
    assign out_Bz     = bz_q;
    assign out_cycles = cycles_q;
    assign out_early  = early_q;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bxs_d    = bxs_q;
        bz_d     = bz_q;
        cycles_d = cycles_q;
        early_d  = early_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                bxs_d   = in_Bxs;
                state_d = CLR;
            end
            CLR: begin
                cyc_d   = '0;
                state_d = RUN;
            end
            RUN: if (stop) begin
                bz_d     = app_Bz;
                cycles_d = cyc_q;
                early_d  = hit_done;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
            HOLD: if (out_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bxs_q     <= '0;
            bz_q      <= '0;
            cycles_q  <= '0;
            early_q   <= 1'b0;
            valid_q   <= 1'b0;
            app_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bxs_q     <= bxs_d;
            bz_q      <= bz_d;
            cycles_q  <= cycles_d;
            early_q   <= early_d;
            valid_q   <= valid_d;
            app_rst_q <= (state_d == RUN);
        end
    end
endmodule

// File: doc/sc_job_ctrl.md
# sc_job_ctrl

Job sequencer for one stochastic-computing application instance, either a pret-based app with a `done` output or an lfsr/sbc-based app without one. It accepts one operand vector per job over a valid/ready handshake and holds those operands stable at the app. It restarts the app from a clean reset for each job, then ends the job on the app's `done` or at a fixed cycle cap. It captures the app's `Bz` and the number of cycles the job used, and presents them downstream over a valid/ready handshake. This makes early-termination savings directly measurable per job.

## Interface
- `W`, default 4: operand width, matching the app.
- `N`, default 4: number of operands, matching the app.
- `NC`, default 1: number of constant streams, matching the app.
- `CORR`, default 0: correlation mode, matching the app.
- `TW` (localparam): `CORR ? W+NC : W*N+NC`, the result width.
- `LEN_W`, default `TW`: cycle cap is `CAP = 2**LEN_W`.
- `USE_DONE`, default 1: 1 = honour `app_done`; 0 = run to `CAP`, with `app_done` ignored.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand vector valid.
- `in_ready`  out  1  controller can accept a job.
- `in_Bxs`  in  `[W-1:0] x N`  operand vector.
- `app_rst_n`  out  1  registered reset to the app, active low.
- `app_Bxs`  out  `[W-1:0] x N`  latched operands to the app.
- `app_Bz`  in  `TW`  app result.
- `app_done`  in  1  app early-termination flag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_Bz`  out  `TW`  captured result.
- `out_cycles`  out  `LEN_W+1`  run cycles used by the job.
- `out_early`  out  1  1 = job ended on `app_done`; 0 = job ended at `CAP`.

## Operation
States: IDLE, CLR, RUN, HOLD. `cyc` is an `LEN_W+1`-bit run counter.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `app_Bxs <= in_Bxs`, go to CLR.
- **CLR**
  - Lasts exactly one cycle.
  - `cyc <= 0`, go to RUN.
- **RUN**, evaluated at every edge:
  - If `USE_DONE & app_done & cyc != 0`: capture, with `out_early <= 1`.
  - Else if `cyc == CAP`: capture, with `out_early <= 0`.
  - Else `cyc <= cyc + 1`.
  - `app_done` seen while `cyc == 0` is ignored, so a stale flag from the previous job cannot end the new one.
  - If `app_done` and the cap coincide, the job ends on `done` (`out_early = 1`).
- **Capture**
  - `out_Bz <= app_Bz`, `out_cycles <= cyc`, `out_valid <= 1`, go to HOLD.
- **HOLD**
  - `out_valid` = 1 and the `out_*` registers stay stable until `out_ready`.
  - On `out_ready`: `out_valid <= 0`, go to IDLE.
- **`app_rst_n`**
  - Registered as `app_rst_n <= (next_state == RUN)`.
  - The app is therefore held in reset in IDLE, CLR and HOLD. Every job starts with at least one low cycle.
- **`app_Bxs`** changes only on an input handshake and holds its value through RUN and HOLD.
- **Backpressure**
  - `in_ready` = 0 in CLR, RUN and HOLD.
  - Upstream must hold `in_valid` and `in_Bxs` until the handshake completes.
- **Reset**
  - Asynchronous `rst_n` low, including mid-job: state IDLE, `in_ready` = 1, `app_rst_n` = 0, `app_Bxs` = 0, `out_valid` = 0, `out_Bz` = 0, `out_cycles` = 0, `out_early` = 0, `cyc` = 0.
  - Any job in flight is discarded and no result is emitted.

## Timing
Edges are counted from the accept edge E0 (the edge where `in_valid & in_ready`).
- E0: state goes to CLR. `app_rst_n` stays 0.
- E1: state goes to RUN, `app_rst_n` goes to 1, `cyc` = 0.
- E(1+k): `cyc` = k. The app has seen k edges out of reset.
- Cap job: captured at E(CAP+2), so `out_valid` rises CAP+2 cycles after the accept edge, with `out_cycles` = CAP.
- Done job: if `app_done` is high while `cyc` = k (k ≥ 1), capture occurs at that edge and `out_cycles` = k.
- Minimum spacing between accept edges is `out_cycles` + 4, with `out_ready` held high.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready` is decoded from state only.

## Test plan
- **Cap path.** `LEN_W` = 5, `USE_DONE` = 0, counter-model app (`Bz` increments every edge out of reset). Send one job, `out_ready` = 1.
  - Required: `out_valid` at E34, `out_Bz` = 32, `out_cycles` = 32, `out_early` = 0.
- **Early termination.** `LEN_W` = 5, `USE_DONE` = 1; the model asserts `done` when its internal count reaches 7.
  - Required: `out_cycles` = 7, `out_Bz` = 7, `out_early` = 1, `app_rst_n` falls the cycle after capture.
- **Stale done.** `app_done` is stuck at 1 from the start of RUN.
  - Required: ignored while `cyc` = 0; job ends with `out_cycles` = 1.
- **Backpressure.** `out_ready` = 0 for 20 cycles after `out_valid`, with a second job pending.
  - Required: `out_*` stable, `in_ready` = 0, second operands not latched. After `out_ready` pulses: IDLE, then the second job is accepted the next cycle.
- **Operand hold.** Change `in_Bxs` after accept, during RUN.
  - Required: `app_Bxs` unchanged until the next handshake.
- **Reset mid-RUN.** Drop `rst_n` at `cyc` = 10.
  - Required: all outputs take their reset values immediately. After release, `in_ready` = 1 and no `out_valid` appears for the aborted job.
